// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory (re/we/addr, tri-state data)
// between N_REQ requesters. One single-cycle access per grant; ack pulse plus read data.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; round-robin pick and field latch
// ACCESS | one memory cycle driven from the latched fields
// ACK    | ack pulse to the latched requester, memory pins quiet
module mem_arbiter #(
  parameter int N_REQ = 2,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic                clock,
  input  logic                reset_L,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  output logic                mem_re,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  inout  wire  [DW-1:0]       mem_data
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_idx;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;

  logic            w_found;
  logic [IW-1:0]   w_sel;
  logic [IW-1:0]   w_cand;
  logic            w_drive;
  logic [N_REQ-1:0] w_ack;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IW'((int'(r_last) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_ACK;
      S_ACK:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_last  <= IW'(N_REQ - 1);
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_last  <= w_sel;
        r_idx   <= w_sel;
        r_we    <= we[w_sel];
        r_addr  <= addr[w_sel*AW +: AW];
        r_wdata <= wdata[w_sel*DW +: DW];
      end
      if (r_state == S_ACCESS && !r_we) begin
        r_rdata <= mem_data;
      end
    end
  end

  // Memory pins depend only on registered state so reset drops them asynchronously.
  always_comb begin
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    w_drive  = 1'b0;
    w_ack    = '0;
    busy     = (r_state == S_ACCESS) || (r_state == S_ACK);
    case (r_state)
      S_ACCESS: begin
        mem_addr = r_addr;
        mem_we   = r_we;
        mem_re   = !r_we;
        w_drive  = r_we;
      end
      S_ACK: begin
        w_ack[r_idx] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign mem_data = w_drive ? r_wdata : {DW{1'bz}};
  assign ack      = w_ack;
  assign rdata    = r_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port Memory instance (re/we/addr, tri-state data) between N_REQ requesters, e.g. game-state logic and the display scanner.
- Latches one request at a time, performs a single-cycle memory access, and returns an ack pulse plus read data.
- Sits between the requesters and the Memory block. It is the only driver of Memory's control pins and the only arbiter-side driver of its data bus.

Parameters:
N_REQ, 2, number of requesters (>=2)
AW, 8, memory address width
DW, 8, memory data width

Ports:
clock  input  1  system clock, all state on posedge
reset_L  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester access request, level
we  input  N_REQ  per-requester 1=write, 0=read
addr  input  N_REQ*AW  flattened addresses, requester i at [i*AW +: AW]
wdata  input  N_REQ*DW  flattened write data, requester i at [i*DW +: DW]
ack  output  N_REQ  one-cycle completion pulse per requester
rdata  output  DW  read data, valid in ack cycle, held until next read completes
busy  output  1  high in ACCESS and ACK states
mem_re  output  1  Memory read enable
mem_we  output  1  Memory write enable
mem_addr  output  AW  Memory address
mem_data  inout  DW  Memory data bus, driven only during write access, else Z

Behaviour:
- Clocking and reset: one clock, `clock`. Reset is `reset_L`, asynchronous and active-low.
- Reset values:
  - State = IDLE, priority pointer `last` = N_REQ-1 (requester 0 ranks highest first).
  - ack=0, rdata=0, busy=0, mem_re=0, mem_we=0, mem_addr=0, mem_data=Z.
  - Latched index, we, addr and wdata = 0.
- FSM has three states: IDLE, ACCESS, ACK.
- IDLE:
  - If any req is high, pick the first requester with req=1 searching (last+1), (last+2), ... mod N_REQ.
  - Latch its index, we, addr and wdata into internal registers.
  - Set last = chosen index and go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr.
  - Latched write: mem_we=1, mem_data = latched wdata.
  - Latched read: mem_re=1, mem_data = Z; capture mem_data into rdata at the end of the cycle.
  - mem_re and mem_we are never both 1.
  - Go to ACK.
- ACK (exactly 1 cycle):
  - ack[latched index]=1, all other ack bits 0.
  - mem_re=mem_we=0, mem_data=Z.
  - Go to IDLE; no arbitration in this state.
- Control outputs are decoded from registered state and latched fields only. No combinational path from req/addr/wdata to the mem_* pins.
- Latency: req sampled high at edge t (IDLE) → ACCESS during cycle t+1 → ack during cycle t+2.
- Throughput: one access per 3 cycles.
- Requester contract: hold req, we, addr and wdata stable until ack is seen. Drop req in the cycle after ack to stop; keeping req high re-enters arbitration at the next IDLE.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N_REQ-1,0,...; no requester waits more than N_REQ transactions.
- Changes to req during ACCESS/ACK are ignored until the next IDLE.
- A requester that drops req before being granted is never granted and never acked.
- Reset mid-operation:
  - mem_we/mem_re fall immediately on reset_L low and mem_data goes to Z.
  - No ack is issued for the aborted transaction. A write coincident with reset assertion is not guaranteed to land.
  - The pointer returns to N_REQ-1.
- rdata is unchanged by writes. It updates only at the end of a read ACCESS.

Test Plan:
- Reset: assert reset_L=0 mid-simulation with req=2'b11 → all outputs 0, mem_data=Z, busy=0. After release, the first grant goes to requester 0.
- Single write then read: req[0]=1, we[0]=1, addr0=8'h05, wdata0=8'hA5 at edge t → mem_we=1, mem_addr=8'h05, mem_data=8'hA5 in cycle t+1, ack=2'b01 in t+2. Then read with we[0]=0, addr0=8'h05 → mem_re=1, mem_data not driven by arbiter, ack=2'b01 with rdata=8'hA5.
- Simultaneous reads: req=2'b11 both held, addr0=8'h01 (holds 8'h11), addr1=8'h02 (holds 8'h22) → ack order 01,10,01,10 every 3 cycles, rdata 8'h11/8'h22 alternating.
- Late arrival fairness: req[1] held continuously, req[0] rises during a requester-1 ACCESS → next grant goes to requester 0, then 1. No back-to-back double grant while the other is waiting.
- Reset during write ACCESS (write addr 8'h07, data 8'h3C): drop reset_L → mem_we falls immediately, no ack pulse, FSM in IDLE, pointer = N_REQ-1.
- Withdrawn request: pulse req[1] for 1 cycle while requester 0's transaction is in ACCESS → ack[1] never asserted, arbiter returns to IDLE with busy=0.
